constraint_scheduler: RTL and testbench

CONSTRAINT_SCHEDULER -- requirements
Module: constraint_scheduler

---
 rtl/constraint_scheduler.sv | 171 +++++++++++++++++
 tb/tb_constraint_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/constraint_scheduler.sv
`timescale 1ns/1ps
// constraint_scheduler
//   Sequences one shared, externally pipelined constraint datapath over a
//   particle chain held in an external position memory. Particle 0 is the
//   anchor and is never written; particles 1..N_PART-1 are relaxed in
//   ascending order for ITERS passes (Gauss-Seidel: each write lands before
//   the next particle's fetch reads it). No arithmetic is done here.
//
//   Per particle: FETCH (4) -> ISSUE (1) -> WAIT (DP_LAT) -> WRITE (1).
//   DP_LAT must be at least 1.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      begin a run (IDLE only) / cancel a run
//   busy, done        run in progress / one-cycle completion pulse
//   mem_raddr         read address; mem_rdata_* valid one cycle later
//   mem_we/waddr/wdata_*  write port (Q16.16 data, passed through)
//   ec_in_valid       operand strobe to the datapath
//   ec_up_*, ec_*, ec_down_*  operands (upper neighbour, self, lower neighbour)
//   ec_res_*          datapath results, valid DP_LAT cycles after ec_in_valid
module constraint_scheduler #(
  parameter int N_PART = 8,
  parameter int ADDR_W = 3,
  parameter int ITERS  = 4,
  parameter int DP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata_x,
  input  logic [31:0]       mem_rdata_y,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata_x,
  output logic [31:0]       mem_wdata_y,
  output logic              ec_in_valid,
  output logic [31:0]       ec_up_x,
  output logic [31:0]       ec_up_y,
  output logic [31:0]       ec_x,
  output logic [31:0]       ec_y,
  output logic [31:0]       ec_down_x,
  output logic [31:0]       ec_down_y,
  input  logic [31:0]       ec_res_x,
  input  logic [31:0]       ec_res_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  // Counter widths hold N_PART-1 and ITERS-1 without wrap.
  localparam int IW = (N_PART > 2) ? $clog2(N_PART) : 1;
  localparam int PW = (ITERS  > 2) ? $clog2(ITERS)  : 1;
  localparam int WW = (DP_LAT > 2) ? $clog2(DP_LAT) : 1;
  localparam bit EMPTY = (N_PART < 2) || (ITERS == 0);
  localparam logic [IW-1:0] I_LAST = IW'(N_PART - 1);
  localparam logic [PW-1:0] P_LAST = PW'(ITERS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(DP_LAT - 1);

  state_t          r_state, w_next;
  logic [IW-1:0]   r_i;
  logic [PW-1:0]   r_p;
  logic [1:0]      r_fcnt;
  logic [WW-1:0]   r_wcnt;
  logic [31:0]     r_up_x, r_up_y, r_x, r_y, r_dn_x, r_dn_y;
  logic [31:0]     r_res_x, r_res_y;
  logic [IW-1:0]   w_down;
  logic            w_last_part;

  // The last particle is its own lower neighbour.
  assign w_last_part = (r_i == I_LAST);
  assign w_down      = w_last_part ? r_i : r_i + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_next = EMPTY ? S_DONE : S_FETCH;
      S_FETCH: if (r_fcnt == 2'd3) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == W_LAST) w_next = S_WRITE;
      S_WRITE: w_next = (w_last_part && r_p == P_LAST) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort beats everything except IDLE, where it is a no-op.
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i    <= '0;
      r_p    <= '0;
      r_fcnt <= '0;
      r_wcnt <= '0;
      r_up_x <= '0; r_up_y <= '0;
      r_x    <= '0; r_y    <= '0;
      r_dn_x <= '0; r_dn_y <= '0;
      r_res_x <= '0; r_res_y <= '0;
    end else begin
      // Phase counters free-run inside their state and park at 0 elsewhere.
      r_fcnt <= (r_state == S_FETCH) ? r_fcnt + 2'd1 : 2'd0;
      r_wcnt <= (r_state == S_WAIT)  ? r_wcnt + WW'(1) : '0;
      case (r_state)
        S_IDLE: if (start && !abort) begin
          r_i <= IW'(1);
          r_p <= '0;
        end
        S_FETCH: begin
          // Read data lags the address by one cycle.
          case (r_fcnt)
            2'd1:    begin r_up_x <= mem_rdata_x; r_up_y <= mem_rdata_y; end
            2'd2:    begin r_x    <= mem_rdata_x; r_y    <= mem_rdata_y; end
            2'd3:    begin r_dn_x <= mem_rdata_x; r_dn_y <= mem_rdata_y; end
            default: ;
          endcase
        end
        S_WAIT: if (r_wcnt == W_LAST) begin
          r_res_x <= ec_res_x;
          r_res_y <= ec_res_y;
        end
        S_WRITE: begin
          if (!w_last_part) begin
            r_i <= r_i + IW'(1);
          end else if (r_p != P_LAST) begin
            r_i <= IW'(1);
            r_p <= r_p + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_raddr = '0;
    if (r_state == S_FETCH) begin
      case (r_fcnt)
        2'd0:    mem_raddr = ADDR_W'(r_i - IW'(1));
        2'd1:    mem_raddr = ADDR_W'(r_i);
        2'd2:    mem_raddr = ADDR_W'(w_down);
        default: mem_raddr = '0;
      endcase
    end
  end

  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE) ||
                       (r_state == S_WAIT)  || (r_state == S_WRITE);
  assign done        = (r_state == S_DONE);
  // An abort during WRITE suppresses that write.
  assign mem_we      = (r_state == S_WRITE) && !abort;
  assign mem_waddr   = (r_state == S_WRITE) ? ADDR_W'(r_i) : '0;
  assign mem_wdata_x = r_res_x;
  assign mem_wdata_y = r_res_y;
  assign ec_in_valid = (r_state == S_ISSUE);
  assign ec_up_x     = r_up_x;
  assign ec_up_y     = r_up_y;
  assign ec_x        = r_x;
  assign ec_y        = r_y;
  assign ec_down_x   = r_dn_x;
  assign ec_down_y   = r_dn_y;

endmodule

// File: tb/tb_constraint_scheduler.sv
`timescale 1ns/1ps
module tb_constraint_scheduler;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int IT = 4;
  localparam int DL = 2;
  localparam int PL = 6 + DL;
  localparam int RUN = IT * (N - 1) * PL;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done, mem_we, ec_in_valid;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [31:0] mem_rdata_x = '0, mem_rdata_y = '0, mem_wdata_x, mem_wdata_y;
  logic [31:0] ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y, ec_res_x, ec_res_y;

  always #5 clk = ~clk;

  constraint_scheduler #(.N_PART(N), .ADDR_W(AW), .ITERS(IT), .DP_LAT(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_raddr(mem_raddr), .mem_rdata_x(mem_rdata_x), .mem_rdata_y(mem_rdata_y),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata_x(mem_wdata_x),
    .mem_wdata_y(mem_wdata_y), .ec_in_valid(ec_in_valid),
    .ec_up_x(ec_up_x), .ec_up_y(ec_up_y), .ec_x(ec_x), .ec_y(ec_y),
    .ec_down_x(ec_down_x), .ec_down_y(ec_down_y),
    .ec_res_x(ec_res_x), .ec_res_y(ec_res_y));

  // Datapath behaviours selectable per test.
  function automatic logic [63:0] dp(input int m, input logic [31:0] ux, uy, x, y, dx, dy);
    case (m)
      0:       return {x + 32'h1_0000, y};
      1:       return {ux + 32'h1_0000, y};
      2:       return {(ux + dx) - x, y ^ uy};
      default: return {(ux >> 1) + (dx >> 1), (uy >> 1) + (dy >> 1)};
    endcase
  endfunction

  // Position memory: one-cycle read latency.
  logic [31:0] mem_x [N];
  logic [31:0] mem_y [N];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_x[mem_waddr] = mem_wdata_x;
      mem_y[mem_waddr] = mem_wdata_y;
    end
    mem_rdata_x <= mem_x[mem_raddr];
    mem_rdata_y <= mem_y[mem_raddr];
  end

  // Datapath responder: DL-stage pipe, junk when no result is due.
  int dp_mode = 0;
  logic [63:0] s1 = '0, s2 = '0;
  logic s1v = 1'b0, s2v = 1'b0;
  always @(posedge clk) begin
    s1v <= ec_in_valid;
    s2v <= s1v;
    s2  <= s1;
    if (ec_in_valid) s1 <= dp(dp_mode, ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y);
  end
  assign ec_res_x = s2v ? s2[63:32] : 32'hDEAD_BEEF;
  assign ec_res_y = s2v ? s2[31:0]  : 32'hBAAD_F00D;

  // Monitor: per-cycle protocol check against the fixed per-particle schedule.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int k = 0, busy_cnt = 0, done_cnt = 0, wr_cnt = 0, iss_cnt = 0;
  int anchor_wr = 0, terr = 0, max_wa = 0, last_done = 0;
  int m_ph, m_pi, m_d;
  logic [191:0] ops, snap = '0;
  assign ops = {ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y};

  always @(negedge clk) begin
    if (busy) begin
      m_ph = k % PL;
      m_pi = (k / PL) % (N - 1) + 1;
      m_d  = (m_pi == N - 1) ? m_pi : m_pi + 1;
      if (m_ph == 0 && mem_raddr != AW'(m_pi - 1)) terr++;
      if (m_ph == 1 && mem_raddr != AW'(m_pi)) terr++;
      if (m_ph == 2 && mem_raddr != AW'(m_d)) terr++;
      if (ec_in_valid != (m_ph == 4)) terr++;
      if (m_ph == 4) begin
        if (ops != {mem_x[m_pi-1], mem_y[m_pi-1], mem_x[m_pi], mem_y[m_pi],
                    mem_x[m_d], mem_y[m_d]}) terr++;
        snap = ops;
      end
      if ((m_ph == 5 || m_ph == 6) && ops != snap) terr++;
      if (mem_we != (m_ph == 7 && !abort)) terr++;
      if (mem_we && mem_waddr != AW'(m_pi)) terr++;
      busy_cnt++;
      k++;
    end else begin
      k = 0;
      if (mem_we || ec_in_valid) terr++;
    end
    if (done) begin
      done_cnt++;
      last_done = cyc;
      if (busy) terr++;
    end
    if (mem_we) begin
      wr_cnt++;
      if (mem_waddr == '0) anchor_wr++;
      if (int'(mem_waddr) > max_wa) max_wa = int'(mem_waddr);
    end
    if (ec_in_valid) iss_cnt++;
  end

  int vecs = 0, errs = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; iss_cnt = 0;
    anchor_wr = 0; terr = 0; max_wa = 0;
  endtask

  // Reference model: plain sweep over the chain, per the relaxation rules.
  logic [31:0] rx [N];
  logic [31:0] ry [N];
  task automatic init_mem(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       begin mem_x[i] = 32'(i) << 16; mem_y[i] = '0; end
        1:       begin mem_x[i] = '0; mem_y[i] = '0; end
        default: begin mem_x[i] = $urandom; mem_y[i] = $urandom; end
      endcase
      rx[i] = mem_x[i];
      ry[i] = mem_y[i];
    end
  endtask

  task automatic ref_run(input int mode);
    for (int p = 0; p < IT; p++)
      for (int i = 1; i < N; i++) begin
        int d;
        logic [63:0] r;
        d = (i == N - 1) ? i : i + 1;
        r = dp(mode, rx[i-1], ry[i-1], rx[i], ry[i], rx[d], ry[d]);
        rx[i] = r[63:32];
        ry[i] = r[31:0];
      end
  endtask

  task automatic wait_done(input int target, input int bound);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin tick(1); n++; end
    check("done_within_bound", 64'(done_cnt >= target), 64'd1);
  endtask

  typedef struct {
    int mode;
    int init;
    int exp_busy;
    int exp_done;
    int exp_wr;
  } vec_t;
  vec_t vt [4];

  task automatic run_vec(input vec_t v);
    dp_mode = v.mode;
    init_mem(v.init);
    ref_run(v.mode);
    clear_stats();
    tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done(1, RUN + 50);
    tick(3);
    check("busy_cycles", 64'(busy_cnt), 64'(v.exp_busy));
    check("done_pulses", 64'(done_cnt), 64'(v.exp_done));
    check("write_count", 64'(wr_cnt), 64'(v.exp_wr));
    check("anchor_writes", 64'(anchor_wr), 64'd0);
    check("schedule_errs", 64'(terr), 64'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("mem_x[%0d]", i), 64'(mem_x[i]), 64'(rx[i]));
      check($sformatf("mem_y[%0d]", i), 64'(mem_y[i]), 64'(ry[i]));
      if (v.mode == 0 && v.init == 0 && i > 0)
        check($sformatf("x_plus4[%0d]", i), 64'(mem_x[i]), 64'((i + 4) << 16));
    end
  endtask

  initial begin
    int n, d1;
    vt[0] = '{mode: 0, init: 0, exp_busy: RUN, exp_done: 1, exp_wr: IT * (N - 1)};
    vt[1] = '{mode: 1, init: 1, exp_busy: RUN, exp_done: 1, exp_wr: IT * (N - 1)};
    vt[2] = '{mode: 2, init: 2, exp_busy: RUN, exp_done: 1, exp_wr: IT * (N - 1)};
    vt[3] = '{mode: 3, init: 2, exp_busy: RUN, exp_done: 1, exp_wr: IT * (N - 1)};
    init_mem(1);

    // Reset state.
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_valid", 64'(ec_in_valid), 64'd0);
    check("rst_data", 64'(|{ops, mem_wdata_x, mem_wdata_y, mem_raddr, mem_waddr}), 64'd0);
    rst = 1'b0;
    tick(2);

    // Abort together with start in IDLE: stays idle.
    clear_stats();
    abort = 1'b1; start = 1'b1; tick(1); abort = 1'b0; start = 1'b0;
    tick(4);
    check("abort_start_idle", 64'(busy_cnt), 64'd0);

    // Table-driven full runs.
    for (int v = 0; v < 4; v++) run_vec(vt[v]);

    // Abort during WAIT of particle 3.
    dp_mode = 0; init_mem(0); clear_stats(); tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    n = 0;
    while (iss_cnt < 3 && n < 100) begin @(negedge clk); n++; end
    check("abort_reach_issue3", 64'(iss_cnt), 64'd3);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy_next", 64'(busy), 64'd0);
    tick(20);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_writes", 64'(wr_cnt), 64'd2);
    check("abort_max_waddr", 64'(max_wa), 64'd2);
    check("abort_p3_kept", 64'(mem_x[3]), 64'(32'd3 << 16));
    check("abort_sched", 64'(terr), 64'd0);

    // Asynchronous reset in the middle of the first WRITE.
    dp_mode = 0; init_mem(0); clear_stats(); tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_we && n < 50);
    check("rst_reach_write", 64'(mem_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_we_drop", 64'(mem_we), 64'd0);
    check("rst_outs_zero", 64'(|{busy, done, ec_in_valid, ops, mem_wdata_x, mem_wdata_y,
                                 mem_raddr, mem_waddr}), 64'd0);
    tick(2); rst = 1'b0; tick(5);
    check("rst_waits_start", 64'(busy), 64'd0);
    check("rst_write_cancelled", 64'(mem_x[1]), 64'(32'd1 << 16));
    check("rst_no_done", 64'(done_cnt), 64'd0);
    run_vec(vt[0]);

    // start held high: back-to-back runs, restart right after DONE/IDLE.
    dp_mode = 1; init_mem(1); clear_stats(); tick(1);
    start = 1'b1;
    wait_done(1, RUN + 50);
    d1 = last_done;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 10);
    check("restart_gap", 64'(cyc - d1), 64'd2);
    wait_done(2, RUN + 50);
    start = 1'b0;
    tick(8);
    check("held_busy", 64'(busy_cnt), 64'(2 * RUN));
    check("held_done", 64'(done_cnt), 64'd2);
    check("held_sched", 64'(terr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
